// File: rtl/makina_pkg.sv
// Shared types for the fetch front end.
// Word width, FSM states and buffer entry layout.
package makina_pkg;
  localparam int XLEN = 17;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and core.
// Flush clears occupancy; the head holds its last value when empty.
module fetch_fifo
  import makina_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  fetch_entry_t last;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = (count != '0) ? mem[rd_ptr] : last;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Remember what was shown so out_* stay put once drained.
  always_ff @(posedge clk) begin
    if (rst) last <= '0;
    else if (count != '0) last <= mem[rd_ptr];
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, one request in flight,
// buffers words for the core, redirect drops stale data.
module instr_fetch
  import makina_pkg::*;
#(
  parameter word_t RESET_PC = '0,
  parameter int    DEPTH    = 2
) (
  input  logic  clk,
  input  logic  rst,
  output logic  imem_req_valid,
  input  logic  imem_req_ready,
  output word_t imem_addr,
  input  logic  imem_resp_valid,
  input  word_t imem_resp_data,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  out_valid,
  input  logic  out_ready,
  output word_t out_instr,
  output word_t out_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_d;
  word_t         fetch_pc;
  word_t         fetch_pc_d;
  word_t         req_pc;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = (state == WAIT) && imem_resp_valid
             && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign wdata = '{pc: req_pc, instr: imem_resp_data};

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  always_comb begin
    count_d = count + CW'(push) - CW'(pop);
    if (redirect_valid) count_d = '0;
  end

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          state_d    = WAIT;
          fetch_pc_d = fetch_pc + 1'b1;
        end
      end
      WAIT, DROP: begin
        if (imem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Anything still owed by memory must be drained in DROP.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      state_d    = (state_d == IDLE) ? IDLE : DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      req_pc         <= RESET_PC;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      if (req_fire) req_pc <= fetch_pc;
      imem_req_valid <= (state_d == IDLE)
                     && (count_d < CW'(DEPTH));
      imem_addr <= fetch_pc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable
// memory and a stream-level model of the delivered PCs.
module tb_instr_fetch;
  import makina_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_addr;
  logic  imem_resp_valid;
  word_t imem_resp_data;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  out_valid;
  logic  out_ready;
  word_t out_instr;
  word_t out_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;

  word_t exp_req;
  word_t exp_out;
  word_t req_log[$];
  word_t dlv_pc[$];
  word_t dlv_instr[$];
  int    dlv_cyc[$];
  word_t mq_data[$];
  int    mq_lat[$];

  instr_fetch #(.RESET_PC('0), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic word_t f(word_t a);
    return word_t'(a * 17'd5 + 17'h00ABC);
  endfunction

  task automatic chk(string nm, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Stream model: requests and deliveries each walk the PC
  // sequence, restarting at reset or redirect targets.
  always @(negedge clk) begin
    if (rst) begin
      exp_req = '0;
      exp_out = '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_req);
        chki("one_outstanding", mq_data.size(), 0);
        req_log.push_back(imem_addr);
        mq_data.push_back(f(imem_addr));
        mq_lat.push_back(lat);
        exp_req = exp_req + 17'd1;
      end
      if (out_valid && out_ready && !redirect_valid) begin
        chk("out_pc", out_pc, exp_out);
        chk("out_instr", out_instr, f(exp_out));
        dlv_pc.push_back(out_pc);
        dlv_instr.push_back(out_instr);
        dlv_cyc.push_back(cyc);
        exp_out = exp_out + 17'd1;
      end
      if (redirect_valid) begin
        exp_req = redirect_pc;
        exp_out = redirect_pc;
      end
    end
  end

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mq_data.size() != 0 && mq_lat[0] <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mq_data.pop_front();
        void'(mq_lat.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mq_data.size() != 0) mq_lat[0] = mq_lat[0] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_instr.delete();
    dlv_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic chk_reset(string nm);
    chki({nm, "_req_valid"}, int'(imem_req_valid), 0);
    chk({nm, "_addr"}, imem_addr, 17'h0);
    chki({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_out_instr"}, out_instr, 17'h0);
    chk({nm, "_out_pc"}, out_pc, 17'h0);
  endtask

  task automatic wait_dlv(string nm, int n, int bound);
    int k = 0;
    while (dlv_pc.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (dlv_pc.size() < n)
      chki({nm, "_dlv_timeout"}, dlv_pc.size(), n);
  endtask

  task automatic wait_req(string nm, int n, int bound);
    int k = 0;
    while (req_log.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (req_log.size() < n)
      chki({nm, "_req_timeout"}, req_log.size(), n);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // 1: basic streaming at latency 1
    lat = 1;
    do_reset();
    chk_reset("t1_reset");
    out_ready = 1'b1;
    wait_dlv("t1", 3, 40);
    chk("t1_req0", req_log[0], 17'h0);
    chk("t1_pc0", dlv_pc[0], 17'h0);
    chk("t1_pc1", dlv_pc[1], 17'h1);
    chk("t1_pc2", dlv_pc[2], 17'h2);
    chk("t1_instr0", dlv_instr[0], 17'h00ABC);
    chk("t1_instr1", dlv_instr[1], 17'h00AC1);
    chki("t1_gap01", dlv_cyc[1] - dlv_cyc[0], 2);
    chki("t1_gap12", dlv_cyc[2] - dlv_cyc[1], 2);

    // 2: back-pressure, credit limits to two requests
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chki("t2_nreq", req_log.size(), 2);
    chk("t2_req0", req_log[0], 17'h0);
    chk("t2_req1", req_log[1], 17'h1);
    chki("t2_req_valid", int'(imem_req_valid), 0);
    chki("t2_full", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_dlv("t2", 3, 40);
    chk("t2_pc0", dlv_pc[0], 17'h0);
    chk("t2_pc1", dlv_pc[1], 17'h1);
    chk("t2_pc2", dlv_pc[2], 17'h2);
    chk("t2_req2", req_log[2], 17'h2);

    // 3: redirect while waiting on memory
    lat = 3;
    out_ready = 1'b0;
    do_reset();
    wait_req("t3", 2, 40);
    chki("t3_buffered", int'(out_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc = 17'h00100;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    chki("t3_flushed", int'(out_valid), 0);
    out_ready = 1'b1;
    wait_dlv("t3", 1, 60);
    chk("t3_pc0", dlv_pc[0], 17'h00100);
    chk("t3_instr0", dlv_instr[0], 17'h00FBC);
    chk("t3_req0", req_log[0], 17'h00100);

    // 4: redirect coinciding with a response
    lat = 1;
    do_reset();
    k = 0;
    while (!imem_resp_valid && k < 20) begin
      tick();
      k++;
    end
    chki("t4_saw_resp", int'(imem_resp_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc = 17'h00040;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    chki("t4_not_pushed", int'(out_valid), 0);
    wait_dlv("t4", 1, 40);
    chk("t4_pc0", dlv_pc[0], 17'h00040);
    chk("t4_req0", req_log[0], 17'h00040);

    // 5: address wrap
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 17'h1FFFF;
    tick();
    redirect_valid = 1'b0;
    wait_dlv("t5", 2, 40);
    chk("t5_req0", req_log[0], 17'h1FFFF);
    chk("t5_req1", req_log[1], 17'h00000);
    chk("t5_pc0", dlv_pc[0], 17'h1FFFF);
    chk("t5_pc1", dlv_pc[1], 17'h00000);
    chk("t5_instr0", dlv_instr[0], 17'h00AB7);

    // 6: stalled memory, then reset during WAIT
    imem_req_ready = 1'b0;
    do_reset();
    tick();
    repeat (3) begin
      tick();
      chki("t6_stall_valid", int'(imem_req_valid), 1);
      chk("t6_stall_addr", imem_addr, 17'h0);
    end
    chki("t6_no_req", req_log.size(), 0);
    lat = 4;
    imem_req_ready = 1'b1;
    wait_req("t6", 1, 10);
    chki("t6_pending", mq_data.size(), 1);
    if (mq_data.size() != 0)
      mq_data[0] = mq_data[0] ^ 17'h15555;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    chk_reset("t6_reset");
    clear_logs();
    rst = 1'b0;
    repeat (8) tick();
    chki("t6_late_ignored", int'(out_valid), 0);
    chki("t6_mem_drained", mq_data.size(), 0);
    imem_req_ready = 1'b1;
    lat = 1;
    wait_dlv("t6", 1, 20);
    chk("t6_pc0", dlv_pc[0], 17'h0);
    chk("t6_instr0", dlv_instr[0], 17'h00ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
